// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave port (DDR2 controller) between
// NUM_MASTERS masters, with tenure-long grants and a per-tenure ack watchdog.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int TIMEOUT     = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [32*NUM_MASTERS-1:0]   wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0]   wbm_dat_i,
  input  logic [4*NUM_MASTERS-1:0]    wbm_sel_i,
  input  logic [3*NUM_MASTERS-1:0]    wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]    wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  output logic [31:0]                 wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [31:0]                 wbs_adr_o,
  output logic [31:0]                 wbs_dat_o,
  output logic [3:0]                  wbs_sel_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  input  logic [31:0]                 wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]             state, state_nxt;
  logic [IW-1:0]          last;
  logic [IW-1:0]          sel_idx;
  logic [IW-1:0]          cand;
  logic                   sel_found;
  logic [NUM_MASTERS-1:0] grant;
  logic [TIMEOUT_W-1:0]   cnt;
  logic                   g_cyc, g_stb, fire;

  // Search upward from last+1 so the previous owner is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = IW'((32'(last) + k) % NUM_MASTERS);
      if (!sel_found && wbm_cyc_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign g_cyc = wbm_cyc_i[last];
  assign g_stb = wbm_stb_i[last];

  // Fires on the cycle the counter would reach TIMEOUT; a same-cycle ack/err wins.
  assign fire = (state == S_BUSY) && g_stb && !wbs_ack_i && !wbs_err_i && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_found) state_nxt = S_BUSY;
      S_BUSY:  if (!g_cyc) state_nxt = S_IDLE;
               else if (fire) state_nxt = S_ERR;
      S_ERR:   state_nxt = g_cyc ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!g_cyc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= S_IDLE;
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && sel_found) begin
        grant <= NUM_MASTERS'(1) << sel_idx;
        last  <= sel_idx;
      end else if (state_nxt == S_IDLE) begin
        grant <= '0;
      end
      if (state != S_BUSY || !g_stb || wbs_ack_i || wbs_err_i)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (state == S_BUSY) begin
      wbs_adr_o = wbm_adr_i[32*last +: 32];
      wbs_dat_o = wbm_dat_i[32*last +: 32];
      wbs_sel_o = wbm_sel_i[4*last +: 4];
      wbs_cti_o = wbm_cti_i[3*last +: 3];
      wbs_bte_o = wbm_bte_i[2*last +: 2];
      wbs_cyc_o = g_cyc;
      wbs_stb_o = g_stb;
      wbs_we_o  = wbm_we_i[last];
      wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i}};
      wbm_err_o = grant & {NUM_MASTERS{wbs_err_i}};
    end else if (state == S_ERR) begin
      wbm_err_o = grant;
    end
  end

  assign timeout_o = (state == S_ERR);
  assign grant_o   = grant;
  assign wbm_rty_o = '0;
  assign wbm_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: single read, round-robin, burst, watchdog,
// ack/timeout tie and mid-tenure reset, with N=3 and TIMEOUT=4.
module tb_wb_ram_arbiter;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [95:0] wbm_adr_i, wbm_dat_i;
  logic [11:0] wbm_sel_i;
  logic [8:0]  wbm_cti_i;
  logic [5:0]  wbm_bte_i;
  logic [2:0]  wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [31:0] wbm_dat_o;
  logic [2:0]  wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i, wbs_err_i;
  logic [2:0]  grant_o;
  logic        timeout_o;

  int compared   = 0;
  int mismatched = 0;

  wb_ram_arbiter #(.NUM_MASTERS(3), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and step just past the edge; inputs change here.
  task automatic nxt();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [2:0] cti);
    wbm_cyc_i[m] = cyc;
    wbm_stb_i[m] = stb;
    wbm_adr_i[m*32 +: 32] = adr;
    wbm_cti_i[m*3 +: 3] = cti;
  endtask

  logic [2:0] oh;

  initial begin
    wb_rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '1; wbm_cti_i = '0; wbm_bte_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
    nxt(); nxt();
    #1;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_wbs_cyc", 32'(wbs_cyc_o), 0);
    chk("rst_ack", 32'(wbm_ack_o), 0);
    chk("rst_err", 32'(wbm_err_o), 0);
    chk("rst_rty", 32'(wbm_rty_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    wb_rst = 1'b0;

    // Single read by master 1, slave acks two cycles after stb
    nxt();
    set_m(1, 1'b1, 1'b1, 32'h1000_0040, 3'b000);
    #1;
    chk("single_idle_grant", 32'(grant_o), 0);
    nxt(); #1;
    chk("single_grant", 32'(grant_o), 32'b010);
    chk("single_wbs_cyc", 32'(wbs_cyc_o), 1);
    chk("single_wbs_adr", wbs_adr_o, 32'h1000_0040);
    nxt(); #1;
    chk("single_no_ack_yet", 32'(wbm_ack_o), 0);
    nxt();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("single_ack", 32'(wbm_ack_o), 32'b010);
    chk("single_dat", wbm_dat_o, 32'hDEAD_BEEF);
    nxt();
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    #1;
    chk("single_ack_one_cycle", 32'(wbm_ack_o), 0);
    nxt(); #1;
    chk("single_release", 32'(grant_o), 0);

    // Reset so master 0 wins first, then round-robin over six tenures
    wb_rst = 1'b1;
    nxt();
    wb_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      oh = 3'b001 << (k % 3);
      wbm_cyc_i = 3'b111; wbm_stb_i = 3'b111;
      #1;
      chk("rr_idle_grant", 32'(grant_o), 0);
      chk("rr_idle_wbs_cyc", 32'(wbs_cyc_o), 0);
      nxt();
      wbs_ack_i = 1'b1;
      #1;
      chk("rr_grant", 32'(grant_o), 32'(oh));
      chk("rr_ack", 32'(wbm_ack_o), 32'(oh));
      nxt();
      wbs_ack_i = 1'b0;
      wbm_cyc_i = wbm_cyc_i & ~oh; wbm_stb_i = wbm_stb_i & ~oh;
      #1;
      chk("rr_grant_held", 32'(grant_o), 32'(oh));
      chk("rr_drop_wbs_cyc", 32'(wbs_cyc_o), 0);
      nxt();
    end
    wbm_cyc_i = '0; wbm_stb_i = '0;

    // Burst by master 0 while master 2 waits
    set_m(0, 1'b1, 1'b1, 32'h2000_0000, 3'b010);
    set_m(2, 1'b1, 1'b1, 32'h3000_0000, 3'b000);
    #1;
    chk("burst_idle", 32'(grant_o), 0);
    for (int b = 0; b < 4; b++) begin
      nxt();
      set_m(0, 1'b1, 1'b1, 32'h2000_0000 + 32'(4*b), (b == 3) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      #1;
      chk("burst_grant", 32'(grant_o), 32'b001);
      chk("burst_ack", 32'(wbm_ack_o), 32'b001);
      chk("burst_cti", 32'(wbs_cti_o), (b == 3) ? 32'b111 : 32'b010);
    end
    nxt();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    #1;
    chk("burst_drop_grant", 32'(grant_o), 32'b001);
    chk("burst_drop_ack", 32'(wbm_ack_o), 0);
    nxt(); #1;
    chk("burst_gap", 32'(grant_o), 0);
    nxt(); #1;
    chk("burst_next_grant", 32'(grant_o), 32'b100);
    chk("to_stb", 32'(wbs_stb_o), 1);

    // Master 2 is never acked: watchdog fires four cycles after stb
    for (int c = 0; c < 3; c++) begin
      nxt(); #1;
      chk("to_no_err", 32'(wbm_err_o), 0);
      chk("to_no_pulse", 32'(timeout_o), 0);
    end
    nxt();
    set_m(0, 1'b1, 1'b1, 32'h0000_0100, 3'b000);
    #1;
    chk("to_err", 32'(wbm_err_o), 32'b100);
    chk("to_pulse", 32'(timeout_o), 1);
    chk("to_wbs_cyc", 32'(wbs_cyc_o), 0);
    nxt();
    wbs_ack_i = 1'b1;
    #1;
    chk("drain_ack_blocked", 32'(wbm_ack_o), 0);
    chk("drain_err", 32'(wbm_err_o), 0);
    chk("drain_pulse", 32'(timeout_o), 0);
    chk("drain_wbs_cyc", 32'(wbs_cyc_o), 0);
    chk("drain_grant", 32'(grant_o), 32'b100);
    nxt();
    wbs_ack_i = 1'b0;
    set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
    #1;
    chk("drain_hold", 32'(grant_o), 32'b100);
    nxt(); #1;
    chk("drain_idle", 32'(grant_o), 0);
    nxt(); #1;
    chk("drain_next_grant", 32'(grant_o), 32'b001);
    nxt();
    set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    nxt(); #1;
    chk("post_to_idle", 32'(grant_o), 0);

    // Ack lands on the cycle the watchdog would otherwise fire
    set_m(1, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
    nxt(); #1;
    chk("tie_grant", 32'(grant_o), 32'b010);
    nxt(); nxt(); #1;
    chk("tie_pre_err", 32'(wbm_err_o), 0);
    nxt();
    wbs_ack_i = 1'b1;
    #1;
    chk("tie_ack", 32'(wbm_ack_o), 32'b010);
    chk("tie_err", 32'(wbm_err_o), 0);
    chk("tie_pulse", 32'(timeout_o), 0);
    nxt();
    wbs_ack_i = 1'b0;
    #1;
    chk("tie_after_pulse", 32'(timeout_o), 0);
    chk("tie_after_err", 32'(wbm_err_o), 0);
    chk("tie_still_busy", 32'(wbs_cyc_o), 1);
    chk("tie_still_grant", 32'(grant_o), 32'b010);

    // Reset in the middle of master 1's tenure
    nxt();
    wb_rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 32'h5000_0000, 3'b000);
    nxt();
    wb_rst = 1'b0;
    #1;
    chk("mrst_grant", 32'(grant_o), 0);
    chk("mrst_wbs_cyc", 32'(wbs_cyc_o), 0);
    chk("mrst_wbs_stb", 32'(wbs_stb_o), 0);
    chk("mrst_wbs_adr", wbs_adr_o, 0);
    chk("mrst_ack", 32'(wbm_ack_o), 0);
    chk("mrst_err", 32'(wbm_err_o), 0);
    chk("mrst_pulse", 32'(timeout_o), 0);
    nxt(); #1;
    chk("mrst_first_grant", 32'(grant_o), 32'b001);
    chk("mrst_first_adr", wbs_adr_o, 32'h5000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
